mult_unit: RTL and testbench

Iterative signed 8×8 multiplier that extends the ALU datapath for the MUL instruction. It sits downstream of the operand-negation/operand-select stage: it consumes the same two 8-bit two's-complement operands the ALU receives. It produces an 8-bit result for the register file. It takes multiple cycles, so it asserts BUSY, which the control unit uses to stall the PC and register-file write until DONE.

---
 rtl/mult_unit.sv | 119 +++++++++++
 tb/tb_mult_unit.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/mult_unit.sv
// Iterative signed 8x8 shift-add multiplier for the MUL instruction.
// Returns the low product byte plus a signed-overflow flag after 9 cycles.
module mult_unit (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       START,
  input  logic [7:0] DATA1,
  input  logic [7:0] DATA2,
  output logic [7:0] RESULT,
  output logic       OVERFLOW,
  output logic       BUSY,
  output logic       DONE
);

  localparam int unsigned W  = 8;
  localparam int unsigned AW = 16;
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_SIGN = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  mcand_q, mcand_d;
  logic [W-1:0]  mplier_q, mplier_d;
  logic          sign_q, sign_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [CW-1:0] count_q, count_d;
  logic [W-1:0]  result_q, result_d;
  logic          overflow_q, overflow_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [AW-1:0] product;

  // State and datapath registers
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q    <= ST_IDLE;
      mcand_q    <= '0;
      mplier_q   <= '0;
      sign_q     <= 1'b0;
      acc_q      <= '0;
      count_q    <= '0;
      result_q   <= '0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      sign_q     <= sign_d;
      acc_q      <= acc_d;
      count_q    <= count_d;
      result_q   <= result_d;
      overflow_q <= overflow_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (START) state_d = ST_CALC;
      ST_CALC: if (count_q == CW'(W - 1)) state_d = ST_SIGN;
      ST_SIGN: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    sign_d     = sign_q;
    acc_d      = acc_q;
    count_d    = count_q;
    result_d   = result_q;
    overflow_d = overflow_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    product    = sign_q ? (~acc_q + AW'(1)) : acc_q;
    case (state_q)
      ST_IDLE: begin
        if (START) begin
          // 0x80 maps to 128, which still fits the unsigned magnitude
          mcand_d  = DATA1[W-1] ? (~DATA1 + W'(1)) : DATA1;
          mplier_d = DATA2[W-1] ? (~DATA2 + W'(1)) : DATA2;
          sign_d   = DATA1[W-1] ^ DATA2[W-1];
          acc_d    = '0;
          count_d  = '0;
          busy_d   = 1'b1;
        end
      end
      ST_CALC: begin
        if (mplier_q[0]) acc_d = acc_q + (AW'(mcand_q) << count_q);
        mplier_d = mplier_q >> 1;
        count_d  = count_q + CW'(1);
      end
      ST_SIGN: begin
        result_d   = product[W-1:0];
        overflow_d = (product[AW-1:W] != {W{product[W-1]}});
        done_d     = 1'b1;
        busy_d     = 1'b0;
      end
      default: ;
    endcase
  end

  assign RESULT   = result_q;
  assign OVERFLOW = overflow_q;
  assign BUSY     = busy_q;
  assign DONE     = done_q;

endmodule

// File: tb/tb_mult_unit.sv
// Bench for mult_unit: directed and random operands against a signed-integer model.
module tb_mult_unit;

  logic       CLK;
  logic       RESET;
  logic       START;
  logic [7:0] DATA1;
  logic [7:0] DATA2;
  logic [7:0] RESULT;
  logic       OVERFLOW;
  logic       BUSY;
  logic       DONE;

  int n_checks;
  int n_fail;

  mult_unit dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .START    (START),
    .DATA1    (DATA1),
    .DATA2    (DATA2),
    .RESULT   (RESULT),
    .OVERFLOW (OVERFLOW),
    .BUSY     (BUSY),
    .DONE     (DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference: full signed product, low byte and range check
  function automatic int model_prod(input logic [7:0] a, input logic [7:0] b);
    int sa;
    int sb;
    sa = {{24{a[7]}}, a};
    sb = {{24{b[7]}}, b};
    return sa * sb;
  endfunction

  // One transaction from idle; times measured in edges after the accept edge
  task automatic do_mult(input logic [7:0] a, input logic [7:0] b,
                         output logic [7:0] r, output logic ov,
                         output int lat, output int busy_cyc, output logic done_after);
    DATA1 = a;
    DATA2 = b;
    START = 1'b1;
    @(posedge CLK);
    #2;
    START = 1'b0;
    lat = 0;
    busy_cyc = 0;
    while (!DONE && lat < 20) begin
      if (BUSY) busy_cyc++;
      @(posedge CLK);
      #2;
      lat++;
    end
    r  = RESULT;
    ov = OVERFLOW;
    @(posedge CLK);
    #2;
    done_after = DONE;
  endtask

  task automatic check_op(input string tag, input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    logic       ov;
    logic       da;
    int         lat;
    int         bc;
    int         p;
    logic [7:0] er;
    logic       eov;
    p   = model_prod(a, b);
    er  = p[7:0];
    eov = (p < -128) || (p > 127);
    do_mult(a, b, r, ov, lat, bc, da);
    n_checks++;
    if (r !== er) begin
      n_fail++;
      $display("FAIL %s result a=%h b=%h got=%h exp=%h", tag, a, b, r, er);
    end
    n_checks++;
    if (ov !== eov) begin
      n_fail++;
      $display("FAIL %s overflow a=%h b=%h got=%b exp=%b", tag, a, b, ov, eov);
    end
    n_checks++;
    if (lat != 9) begin
      n_fail++;
      $display("FAIL %s latency got=%0d exp=9", tag, lat);
    end
    n_checks++;
    if (bc != 9) begin
      n_fail++;
      $display("FAIL %s busy_cycles got=%0d exp=9", tag, bc);
    end
    n_checks++;
    if (da !== 1'b0) begin
      n_fail++;
      $display("FAIL %s done_fall got=%b exp=0", tag, da);
    end
  endtask

  task automatic test_reset();
    RESET = 1'b0;
    START = 1'b0;
    DATA1 = 8'h00;
    DATA2 = 8'h00;
    repeat (2) @(posedge CLK);
    #2;
    n_checks++;
    if (RESULT !== 8'h00) begin n_fail++; $display("FAIL reset_result got=%h exp=00", RESULT); end
    n_checks++;
    if (OVERFLOW !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got=%b exp=0", OVERFLOW); end
    n_checks++;
    if (BUSY !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", BUSY); end
    n_checks++;
    if (DONE !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", DONE); end
    RESET = 1'b1;
    @(posedge CLK);
    #2;
  endtask

  task automatic test_directed();
    logic [7:0] ta [8];
    logic [7:0] tb [8];
    ta = '{8'd7, 8'hFD, 8'hFB, 8'h80, 8'd20, 8'h80, 8'h00, 8'h7F};
    tb = '{8'd6, 8'h05, 8'hFD, 8'hFF, 8'd20, 8'h01, 8'h80, 8'h7F};
    for (int i = 0; i < 8; i++) check_op("directed", ta[i], tb[i]);
  endtask

  task automatic test_random();
    logic [7:0] a;
    logic [7:0] b;
    for (int i = 0; i < 30; i++) begin
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      check_op("random", a, b);
    end
  endtask

  task automatic test_back_to_back();
    int k;
    DATA1 = 8'd3;
    DATA2 = 8'd4;
    START = 1'b1;
    @(posedge CLK);
    #2;
    START = 1'b0;
    repeat (3) @(posedge CLK);
    #2;
    DATA1 = 8'd9;
    DATA2 = 8'd9;
    START = 1'b1;
    @(posedge CLK);
    #2;
    START = 1'b0;
    k = 4;
    while (!DONE && k < 25) begin
      @(posedge CLK);
      #2;
      k++;
    end
    n_checks++;
    if (k != 9) begin n_fail++; $display("FAIL ignore_start_latency got=%0d exp=9", k); end
    n_checks++;
    if (RESULT !== 8'h0C) begin n_fail++; $display("FAIL ignore_start_result got=%h exp=0c", RESULT); end
    DATA1 = 8'd2;
    DATA2 = 8'd2;
    START = 1'b1;
    @(posedge CLK);
    #2;
    k = 10;
    n_checks++;
    if (BUSY !== 1'b1) begin n_fail++; $display("FAIL held_start_accept busy=%b exp=1", BUSY); end
    while (!DONE && k < 30) begin
      @(posedge CLK);
      #2;
      k++;
    end
    START = 1'b0;
    n_checks++;
    if (k != 19) begin n_fail++; $display("FAIL held_start_done_edge got=%0d exp=19", k); end
    n_checks++;
    if (RESULT !== 8'h04) begin n_fail++; $display("FAIL held_start_result got=%h exp=04", RESULT); end
    @(posedge CLK);
    #2;
  endtask

  task automatic test_reset_mid();
    int seen_done;
    DATA1 = 8'd5;
    DATA2 = 8'd5;
    START = 1'b1;
    @(posedge CLK);
    #2;
    START = 1'b0;
    repeat (5) @(posedge CLK);
    #2;
    RESET = 1'b0;
    #1;
    n_checks++;
    if (BUSY !== 1'b0) begin n_fail++; $display("FAIL midreset_busy got=%b exp=0", BUSY); end
    n_checks++;
    if (DONE !== 1'b0) begin n_fail++; $display("FAIL midreset_done got=%b exp=0", DONE); end
    n_checks++;
    if (RESULT !== 8'h00) begin n_fail++; $display("FAIL midreset_result got=%h exp=00", RESULT); end
    @(posedge CLK);
    #2;
    RESET = 1'b1;
    seen_done = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge CLK);
      #2;
      if (DONE || BUSY) seen_done++;
    end
    n_checks++;
    if (seen_done != 0) begin n_fail++; $display("FAIL midreset_no_done got=%0d exp=0", seen_done); end
    check_op("after_reset", 8'd5, 8'd5);
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
